// File: rtl/mmio_timer_tx.sv
// Memory-mapped machine timer with compare interrupt and a byte transmit FIFO,
// decoded in a 256-byte window beside the data memory.
module mmio_timer_tx #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          TX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mem_we,
  output logic [31:0] dout,
  output logic        hit,
  output logic        timer_irq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = $clog2(TX_DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  typedef enum logic [5:0] {
    REG_MTIME_LO    = 6'h00,
    REG_MTIME_HI    = 6'h01,
    REG_MTIMECMP_LO = 6'h02,
    REG_MTIMECMP_HI = 6'h03,
    REG_TXDATA      = 6'h04,
    REG_STATUS      = 6'h05,
    REG_CTRL        = 6'h06
  } reg_sel_t;

  logic [63:0] mtime, mtime_next;
  logic [63:0] mtimecmp;
  logic [1:0]  ctrl;
  logic        overflow;
  logic [7:0]  fifo_mem [TX_DEPTH];
  ptr_t        wr_ptr, rd_ptr;
  cnt_t        count;

  logic [5:0]  word;
  logic        wr;
  logic        push_req, push, pop, full, empty;
  logic        ovf_set, ovf_clr;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    return res;
  endfunction

  assign word             = addr[7:2];
  assign unused_addr_bits = ^addr[1:0];
  assign hit              = (addr[31:8] == BASE_ADDR[31:8]);
  assign wr               = hit && (mem_we != 4'b0000);

  assign empty    = (count == '0);
  assign full     = (count == cnt_t'(TX_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[rd_ptr];

  assign pop      = tx_valid && tx_ready;
  assign push_req = wr && (word == REG_TXDATA) && mem_we[0];
  // A full FIFO still accepts a push when the sink drains an entry the same cycle.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = wr && (word == REG_STATUS) && mem_we[0] && din[2];

  // A software write to either half suspends counting and carry for that cycle.
  always_comb begin
    mtime_next = mtime;
    if (wr && word == REG_MTIME_LO)
      mtime_next[31:0] = merge_bytes(mtime[31:0], din, mem_we);
    else if (wr && word == REG_MTIME_HI)
      mtime_next[63:32] = merge_bytes(mtime[63:32], din, mem_we);
    else if (ctrl[0])
      mtime_next = mtime + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      ctrl      <= '0;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime_next;
      timer_irq <= ctrl[1] && (mtime >= mtimecmp);
      if (wr && word == REG_MTIMECMP_LO)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], din, mem_we);
      if (wr && word == REG_MTIMECMP_HI)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], din, mem_we);
      if (wr && word == REG_CTRL && mem_we[0])
        ctrl <= din[1:0];
    end
  end

  // Storage is cleared on reset so tx_data reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < TX_DEPTH; i++)
        fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= din[7:0];
        wr_ptr           <= wr_ptr + ptr_t'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + ptr_t'(1);
      if (push && !pop)
        count <= count + cnt_t'(1);
      else if (pop && !push)
        count <= count - cnt_t'(1);
      if (ovf_set)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (word)
      REG_MTIME_LO:    rdata = mtime[31:0];
      REG_MTIME_HI:    rdata = mtime[63:32];
      REG_MTIMECMP_LO: rdata = mtimecmp[31:0];
      REG_MTIMECMP_HI: rdata = mtimecmp[63:32];
      REG_STATUS:      rdata = {16'h0000, 8'(count), 5'b00000, overflow, full, empty};
      REG_CTRL:        rdata = {30'b0, ctrl};
      default:         rdata = '0;
    endcase
  end

  assign dout = hit ? rdata : 32'h0;

endmodule

// File: tb/tb_mmio_timer_tx.sv
// Self-checking bench for mmio_timer_tx: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_mmio_timer_tx;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, din, dout;
  logic [3:0]  mem_we;
  logic        hit, timer_irq, tx_valid, tx_ready;
  logic [7:0]  tx_data;

  int checks   = 0;
  int failures = 0;

  logic [63:0] m_mtime, m_cmp;
  logic [1:0]  m_ctrl;
  logic        m_ovf, m_irq;
  logic [7:0]  m_q[$];

  logic [31:0] pre_dout;
  logic        pre_hit;

  mmio_timer_tx #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .din(din), .mem_we(mem_we),
    .dout(dout), .hit(hit), .timer_irq(timer_irq), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic        ready;
    logic        exp_hit;
    logic [31:0] exp_dout;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] byteMerge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0] we);
    logic [31:0] mask;
    mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a[31:8] != BASE[31:8]) return 32'h0;
    case (a[7:0] & 8'hFC)
      8'h00: return m_mtime[31:0];
      8'h04: return m_mtime[63:32];
      8'h08: return m_cmp[31:0];
      8'h0C: return m_cmp[63:32];
      8'h14: return {16'h0, 8'(m_q.size()), 5'b0, m_ovf,
                     (m_q.size() == DEPTH), (m_q.size() == 0)};
      8'h18: return {30'b0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  task automatic resetModel();
    m_mtime = 64'h0;
    m_cmp   = '1;
    m_ctrl  = 2'b00;
    m_ovf   = 1'b0;
    m_irq   = 1'b0;
    m_q.delete();
  endtask

  task automatic modelStep(input logic r, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] w, input logic rdy);
    logic       wr, push, pop, was_full, nxt_irq;
    logic [7:0] off;
    if (!r) begin
      resetModel();
      return;
    end
    wr       = (a[31:8] == BASE[31:8]) && (w != 4'b0);
    off      = a[7:0] & 8'hFC;
    nxt_irq  = m_ctrl[1] && (m_mtime >= m_cmp);
    pop      = (m_q.size() != 0) && rdy;
    was_full = (m_q.size() == DEPTH);
    push     = wr && off == 8'h10 && w[0];
    if (wr && off == 8'h00)      m_mtime[31:0]  = byteMerge(m_mtime[31:0], d, w);
    else if (wr && off == 8'h04) m_mtime[63:32] = byteMerge(m_mtime[63:32], d, w);
    else if (m_ctrl[0])          m_mtime        = m_mtime + 64'd1;
    if (wr && off == 8'h08) m_cmp[31:0]  = byteMerge(m_cmp[31:0], d, w);
    if (wr && off == 8'h0C) m_cmp[63:32] = byteMerge(m_cmp[63:32], d, w);
    if (wr && off == 8'h18 && w[0]) m_ctrl = d[1:0];
    if (wr && off == 8'h14 && w[0] && d[2]) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (was_full && !pop) m_ovf = 1'b1;
      else m_q.push_back(d[7:0]);
    end
    m_irq = nxt_irq;
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] w, input logic rdy);
    rst_n    = r;
    addr     = a;
    din      = d;
    mem_we   = w;
    tx_ready = rdy;
    #1;
    pre_dout = dout;
    pre_hit  = hit;
    checkOutput("model_hit", hit, (a[31:8] == BASE[31:8]));
    checkOutput("model_dout", dout, modelRead(a));
    modelStep(r, a, d, w, rdy);
    @(posedge clk);
    #1;
    checkOutput("model_irq", timer_irq, m_irq);
    checkOutput("model_tx_valid", tx_valid, (m_q.size() != 0));
    if (m_q.size() != 0)
      checkOutput("model_tx_data", tx_data, m_q[0]);
  endtask

  initial begin
    int         rise_n;
    logic [7:0] drain_exp[8];
    logic [7:0] off_tab[8];

    vecs[0]  = '{1'b0, BASE + 32'h10,  32'hAA,        4'hF, 1'b1, 1'b1, 32'h0,        1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b0, 1'b1, 32'h1,        1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, BASE + 32'h08,  32'h0,         4'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, BASE + 32'h0C,  32'h0,         4'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, BASE + 32'h10,  32'h11,        4'h1, 1'b0, 1'b1, 32'h0,        1'b1, 8'h11, 1'b0};
    vecs[5]  = '{1'b1, BASE + 32'h10,  32'h22,        4'h1, 1'b0, 1'b1, 32'h0,        1'b1, 8'h11, 1'b0};
    vecs[6]  = '{1'b1, BASE + 32'h10,  32'h33,        4'h1, 1'b0, 1'b1, 32'h0,        1'b1, 8'h11, 1'b0};
    vecs[7]  = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b0, 1'b1, 32'h300,      1'b1, 8'h11, 1'b0};
    vecs[8]  = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b1, 1'b1, 32'h300,      1'b1, 8'h22, 1'b0};
    vecs[9]  = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b1, 1'b1, 32'h200,      1'b1, 8'h33, 1'b0};
    vecs[10] = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b1, 1'b1, 32'h100,      1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b0, 1'b1, 32'h1,        1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b1, BASE + 32'h100, 32'hFFFFFFFF,  4'hF, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, BASE + 32'h1C,  32'hFFFFFFFF,  4'hF, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b1, BASE + 32'h10,  32'h55,        4'hE, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00, 1'b0};
    vecs[15] = '{1'b1, BASE + 32'h14,  32'h0,         4'h0, 1'b0, 1'b1, 32'h1,        1'b0, 8'h00, 1'b0};
    vecs[16] = '{1'b1, BASE + 32'h00,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00, 1'b0};
    vecs[17] = '{1'b1, BASE + 32'h18,  32'h0,         4'h0, 1'b0, 1'b1, 32'h0,        1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; addr = '0; din = '0; mem_we = '0; tx_ready = 1'b0;
    @(posedge clk);
    #1;
    resetModel();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].addr, vecs[i].din, vecs[i].we, vecs[i].ready);
      checkOutput($sformatf("vec%0d_hit", i), pre_hit, vecs[i].exp_hit);
      checkOutput($sformatf("vec%0d_dout", i), pre_dout, vecs[i].exp_dout);
      checkOutput($sformatf("vec%0d_valid", i), tx_valid, vecs[i].exp_valid);
      checkOutput($sformatf("vec%0d_irq", i), timer_irq, vecs[i].exp_irq);
      if (vecs[i].exp_valid || !vecs[i].rst_n)
        checkOutput($sformatf("vec%0d_data", i), tx_data, vecs[i].exp_data);
    end

    applyStimulus(1, BASE + 32'h00, 32'hFFFF_FFFE, 4'hF, 0);
    applyStimulus(1, BASE + 32'h04, 32'h0, 4'hF, 0);
    applyStimulus(1, BASE + 32'h18, 32'h1, 4'hF, 0);
    applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
    applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
    applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
    checkOutput("carry_mtime_lo", pre_dout, 32'h0);
    applyStimulus(1, BASE + 32'h04, 32'h0, 4'h0, 0);
    checkOutput("carry_mtime_hi", pre_dout, 32'h1);
    applyStimulus(1, BASE + 32'h18, 32'h0, 4'hF, 0);
    applyStimulus(1, BASE + 32'h00, 32'h1234_5678, 4'hF, 0);
    applyStimulus(1, BASE + 32'h00, 32'h0000_AB00, 4'b0010, 0);
    applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
    checkOutput("byte_write_lo", pre_dout, 32'h1234_AB78);

    applyStimulus(1, BASE + 32'h00, 32'h0, 4'hF, 0);
    applyStimulus(1, BASE + 32'h04, 32'h0, 4'hF, 0);
    applyStimulus(1, BASE + 32'h08, 32'd10, 4'hF, 0);
    applyStimulus(1, BASE + 32'h0C, 32'h0, 4'hF, 0);
    applyStimulus(1, BASE + 32'h18, 32'h3, 4'hF, 0);
    rise_n = 0;
    for (int n = 1; n <= 40; n++) begin
      applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
      if (timer_irq) begin
        rise_n = n;
        break;
      end
    end
    checkOutput("irq_rise_cycle", rise_n, 11);
    checkOutput("irq_rise_mtime", pre_dout, 32'd10);
    applyStimulus(1, BASE + 32'h08, 32'd100, 4'hF, 0);
    checkOutput("irq_lag_after_cmp_write", timer_irq, 1'b1);
    applyStimulus(1, BASE + 32'h00, 32'h0, 4'h0, 0);
    checkOutput("irq_cleared", timer_irq, 1'b0);
    applyStimulus(1, BASE + 32'h18, 32'h0, 4'hF, 0);

    for (int i = 0; i < 9; i++)
      applyStimulus(1, BASE + 32'h10, 32'h40 + i, 4'h1, 0);
    applyStimulus(1, BASE + 32'h14, 32'h0, 4'h0, 0);
    checkOutput("full_status", pre_dout, 32'h0000_0806);
    applyStimulus(1, BASE + 32'h10, 32'h99, 4'h1, 1);
    checkOutput("full_push_pop_head", tx_data, 8'h41);
    applyStimulus(1, BASE + 32'h14, 32'h0, 4'h0, 0);
    checkOutput("full_push_pop_status", pre_dout, 32'h0000_0806);
    applyStimulus(1, BASE + 32'h14, 32'h4, 4'h1, 0);
    applyStimulus(1, BASE + 32'h14, 32'h0, 4'h0, 0);
    checkOutput("overflow_cleared", pre_dout, 32'h0000_0802);
    drain_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h99};
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("drain%0d", i), tx_data, drain_exp[i]);
      applyStimulus(1, BASE + 32'h14, 32'h0, 4'h0, 1);
    end
    checkOutput("drain_empty", tx_valid, 1'b0);

    off_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      logic [3:0]  w;
      logic        r;
      a = BASE | {24'h0, off_tab[$urandom_range(7)]} | 32'($urandom_range(3));
      if ($urandom_range(15) == 0) a = a ^ 32'h0000_0100;
      w = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      r = ($urandom_range(99) != 0);
      applyStimulus(r, a, $urandom, w, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_timer_tx.md
Name: mmio_timer_tx

Overview:
- Memory-mapped responder on the core's data-memory port: same addr/din/mem_we/dout signalling as the data memory, decoded at a 256-byte window at BASE_ADDR.
- Provides a 64-bit machine timer with compare interrupt.
- Provides a byte transmit FIFO drained through a valid/ready stream.
- Sits beside the data memory. The top-level mux selects its dout when the address hits its window.

Parameters:
- BASE_ADDR, 32'h8000_0000, window base; bits [7:0] must be zero.
- TX_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- addr  in  32  byte address from core (alu_addr)
- din  in  32  store data from core (rs2_val_sx)
- mem_we  in  4  per-byte write enables; bit i covers din[8i+7:8i]
- dout  out  32  read data, combinational from addr
- hit  out  1  combinational, addr[31:8]==BASE_ADDR[31:8]
- timer_irq  out  1  registered timer interrupt
- tx_data  out  8  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  sink accepts tx_data when tx_valid&tx_ready

Behaviour:
- Register map (offset = addr[7:0]; addr[1:0] ignored):
  - 0x00 MTIME_LO  RW
  - 0x04 MTIME_HI  RW
  - 0x08 MTIMECMP_LO  RW
  - 0x0C MTIMECMP_HI  RW
  - 0x10 TXDATA  W, reads 0
  - 0x14 STATUS  R: [0] empty, [1] full, [2] overflow (sticky), [15:8] count
  - 0x18 CTRL  RW: [0] timer_en, [1] irq_en
  - all other offsets read 0; writes to them are ignored.
- Reads: dout = selected register when hit, else 0. Reads have no side effects.
- Writes: take effect at the clock edge when hit and mem_we!=0. Writable registers update only the enabled bytes.
- Reset (rst_n low at edge):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, FIFO empty, overflow=0.
  - timer_irq=0, tx_valid=0, tx_data=0.
- Timer:
  - If timer_en, mtime increments by 1 each cycle as a 64-bit counter with carry from LO to HI; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A write to MTIME_LO or MTIME_HI in a cycle overrides that half for that cycle; the other half holds, with no increment and no carry that cycle.
  - timer_irq is registered: next = irq_en & (mtime >= mtimecmp), compared as unsigned 64-bit using current-cycle register values. It therefore lags a causal write by 1 cycle.
  - The interrupt is cleared by writing mtimecmp above mtime, or by clearing irq_en.
- TX FIFO:
  - Push happens when hit, offset 0x10 and mem_we[0]; din[7:0] is enqueued.
  - Pop happens when tx_valid & tx_ready.
  - A push while full with no simultaneous pop is dropped and sets overflow. Full with a simultaneous pop: both occur, count stays TX_DEPTH.
  - Simultaneous push and pop when not full: count is unchanged.
  - tx_valid = (count!=0); tx_data = head entry; both are registered state. A push into an empty FIFO shows tx_valid=1 on the next cycle.
  - Writing STATUS with mem_we[0] and din[2]=1 clears overflow. Overflow set and clear in the same cycle: set wins.
  - Pointers wrap modulo TX_DEPTH; count ranges 0..TX_DEPTH.
- Reset mid-operation discards FIFO contents and timer state regardless of the other inputs that cycle.

Test Plan:
- Reset with stimulus active: assert rst_n=0 while mem_we=4'hF and tx_ready=1 -> next cycle dout@0x14=32'h1, @0x08/0x0C=FFFF_FFFF, timer_irq=0, tx_valid=0.
- Timer carry: write MTIME_LO=FFFF_FFFE, MTIME_HI=0, CTRL=1 -> after 2 cycles MTIME_LO=0, MTIME_HI=1; a byte write mem_we=4'b0010 din=32'h0000_AB00 to MTIME_LO replaces only byte 1.
- Interrupt: mtime=0, MTIMECMP=10, CTRL=3 -> timer_irq rises in the cycle after mtime reaches 10; writing MTIMECMP_LO=100 drops it one cycle later.
- FIFO order and backpressure: push 0x11,0x22,0x33 with tx_ready=0 -> count=3, tx_data=0x11. Raise tx_ready -> sink sees 0x11,0x22,0x33 on consecutive cycles, then tx_valid=0.
- Full boundary: with TX_DEPTH=8, push 9 bytes with tx_ready=0 -> STATUS=32'h0000_0806 and the 9th byte is dropped. Push while full with tx_ready=1 -> accepted, count stays 8. Write STATUS din=4 -> overflow clears.
- Decode: addr=BASE_ADDR+0x100 or 0x1C with mem_we=F -> hit=0 or read 0 respectively, and no state changes; a TXDATA write with mem_we=4'b1110 -> no push.
